// File: rtl/data_hs_pkg.sv
// Shared types and helpers for the data handshake arbiter.
package data_hs_pkg;

    // Arbiter state: free to pick a new requester, or locked onto one packet.
    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Width of a port index; never below one bit so a two-port arbiter still
    // has a usable index.
    function automatic int idx_width(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/data_hs_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          any
);

    logic [IW-1:0] idx;

    // Scan from the farthest offset back to ptr so the nearest request wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % N);
            if (req[idx]) begin
                grant = idx;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_hs.sv
// Packet-locking round-robin arbiter with a single registered output stage.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no packet open; grant follows the round-robin scan from rr_ptr
// LOCK  | mid-packet; only lock_id is granted until its last beat
module data_hs_arb
    import data_hs_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int D_WIDTH = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [N_PORTS*D_WIDTH-1:0]   in_data_i,
    input  logic [N_PORTS-1:0]           in_valid_i,
    input  logic [N_PORTS-1:0]           in_last_i,
    output logic [N_PORTS-1:0]           in_ready_o,
    output logic [D_WIDTH-1:0]           out_data_o,
    output logic                         out_last_o,
    output logic [$clog2(N_PORTS)-1:0]   out_id_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic                         busy_o
);

    localparam int IW = idx_width(N_PORTS);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] lock_id_q, lock_id_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;

    logic          stage_en;
    logic [IW-1:0] pick_grant;
    logic          pick_any;
    logic [IW-1:0] grant;
    logic          grant_active;
    logic          xfer;
    logic [D_WIDTH-1:0] sel_data;
    logic          sel_last;

    function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] v);
        if (int'(v) == N_PORTS - 1) begin
            return '0;
        end
        return v + IW'(1);
    endfunction

    assign stage_en = out_ready_i | ~out_valid_o;
    assign busy_o   = (state_q == LOCK);

    rr_pick #(
        .N  (N_PORTS),
        .IW (IW)
    ) u_pick (
        .req   (in_valid_i),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .any   (pick_any)
    );

    // Grant selection: the locked port owns the output for the whole packet,
    // even while it is not presenting a beat (that is what makes bubbles).
    always_comb begin
        grant        = pick_grant;
        grant_active = pick_any;
        if (state_q == LOCK) begin
            grant        = lock_id_q;
            grant_active = 1'b1;
        end
    end

    // Granted requester's beat, taken straight from the inputs.
    always_comb begin
        sel_data = in_data_i[int'(grant)*D_WIDTH +: D_WIDTH];
        sel_last = in_last_i[grant];
        xfer     = stage_en & grant_active & in_valid_i[grant];
    end

    // Ready goes only to the granted port and only when the stage can accept.
    always_comb begin
        in_ready_o = '0;
        if (stage_en && grant_active) begin
            in_ready_o[grant] = 1'b1;
        end
    end

    // Next-state: lock on a non-final beat, release on the locked port's last
    // beat; the round-robin pointer moves only when a packet completes.
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        rr_ptr_d  = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (xfer && !sel_last) begin
                    state_d   = LOCK;
                    lock_id_d = grant;
                end
            end
            LOCK: begin
                if (xfer && sel_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (xfer && sel_last) begin
            rr_ptr_d = inc_wrap(grant);
        end
    end

    // State, lock owner and pointer registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            lock_id_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    // Output stage: load on transfer, drop valid on an empty accepted slot,
    // hold everything while downstream stalls.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            out_valid_o <= 1'b0;
            out_last_o  <= 1'b0;
            out_data_o  <= '0;
            out_id_o    <= '0;
        end else if (stage_en) begin
            if (xfer) begin
                out_valid_o <= 1'b1;
                out_last_o  <= sel_last;
                out_data_o  <= sel_data;
                out_id_o    <= grant;
            end else begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_hs_arb.sv
// Scoreboard bench for data_hs_arb: requester queues feed the inputs,
// expected beats are queued with the stimulus, a monitor checks the output.
module tb_data_hs_arb;

    localparam int NP = 4;
    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            gap;
    } beat_t;

    typedef struct {
        logic [1:0]    id;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic [NP*DW-1:0]  in_data_i;
    logic [NP-1:0]     in_valid_i;
    logic [NP-1:0]     in_last_i;
    logic [NP-1:0]     in_ready_o;
    logic [DW-1:0]     out_data_o;
    logic              out_last_o;
    logic [1:0]        out_id_o;
    logic              out_valid_o;
    logic              out_ready_i;
    logic              busy_o;

    beat_t port_q[NP][$];
    exp_t  exp_q[$];
    int    gap_cnt[NP];
    logic [NP-1:0] fire;
    bit    rand_mode;

    int n_cmp = 0;
    int n_err = 0;

    data_hs_arb #(.N_PORTS(NP), .D_WIDTH(DW)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_last_i   (in_last_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .out_id_o    (out_id_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [DW-1:0] mk(input int t, input int p, input int n);
        return DW'((t << 16) | (p << 8) | n);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input int p, input logic [DW-1:0] d, input logic last, input int gap);
        beat_t b;
        b.data = d;
        b.last = last;
        b.gap  = gap;
        port_q[p].push_back(b);
    endtask

    task automatic exp_beat(input int p, input logic [DW-1:0] d, input logic last);
        exp_t e;
        e.id   = 2'(p);
        e.data = d;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic wait_data(input string name, input logic [DW-1:0] d);
        bit seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk_i);
            if (out_valid_o && out_data_o == d) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s: got no beat in 100 cycles, required data %0h", name, d);
        end
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk_i);
        chk(name, 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk_i);
    endtask

    // Requester model: a beat leaves its queue when the handshake seen just
    // before the edge completes; an optional gap holds valid low first.
    always begin
        @(negedge clk_i);
        for (int i = 0; i < NP; i++)
            fire[i] = (rst_n_i === 1'b1) && in_valid_i[i] && in_ready_o[i];
        @(posedge clk_i);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (fire[i] && port_q[i].size() > 0) begin
                void'(port_q[i].pop_front());
                gap_cnt[i] = (port_q[i].size() > 0) ? port_q[i][0].gap : 0;
            end else if (gap_cnt[i] > 0) begin
                gap_cnt[i]--;
            end
            if (rand_mode) begin
                in_valid_i[i]           = 1'($urandom_range(0, 1));
                in_last_i[i]            = 1'($urandom_range(0, 1));
                in_data_i[i*DW +: DW]   = $urandom;
            end else if (port_q[i].size() > 0 && gap_cnt[i] == 0) begin
                in_valid_i[i]           = 1'b1;
                in_last_i[i]            = port_q[i][0].last;
                in_data_i[i*DW +: DW]   = port_q[i][0].data;
            end else begin
                in_valid_i[i]           = 1'b0;
                in_last_i[i]            = 1'b0;
                in_data_i[i*DW +: DW]   = '0;
            end
        end
    end

    // Output monitor: every accepted output beat must match the next expected one.
    always @(negedge clk_i) begin
        if (rst_n_i === 1'b1 && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_beat: got id %0d data %0h, expected no beat", out_id_o, out_data_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("beat_id",   64'(out_id_o),   64'(e.id));
                chk("beat_data", 64'(out_data_o), 64'(e.data));
                chk("beat_last", 64'(out_last_o), 64'(e.last));
            end
        end
    end

    initial begin
        logic [NP-1:0] v;
        logic [DW-1:0] hold;

        rst_n_i     = 1'b0;
        out_ready_i = 1'b1;
        rand_mode   = 1'b1;
        in_valid_i  = '0;
        in_last_i   = '0;
        in_data_i   = '0;
        for (int i = 0; i < NP; i++) gap_cnt[i] = 0;

        // Reset with random requesters: ready still reflects the scan from port 0.
        repeat (3) begin
            @(negedge clk_i);
            v = in_valid_i;
            chk("reset_ready", 64'(in_ready_o), 64'(v & (~v + 4'd1)));
        end
        #1 rand_mode = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("reset_valid", 64'(out_valid_o), 64'd0);
        chk("reset_id",    64'(out_id_o),    64'd0);
        chk("reset_busy",  64'(busy_o),      64'd0);
        chk("reset_data",  64'(out_data_o),  64'd0);

        // Fairness: single-beat packets on all ports -> 0,1,2,3,0,1 back to back.
        #1;
        push_beat(0, mk(1, 0, 0), 1'b1, 0);
        push_beat(0, mk(1, 0, 1), 1'b1, 0);
        push_beat(1, mk(1, 1, 0), 1'b1, 0);
        push_beat(1, mk(1, 1, 1), 1'b1, 0);
        push_beat(2, mk(1, 2, 0), 1'b1, 0);
        push_beat(3, mk(1, 3, 0), 1'b1, 0);
        exp_beat(0, mk(1, 0, 0), 1'b1);
        exp_beat(1, mk(1, 1, 0), 1'b1);
        exp_beat(2, mk(1, 2, 0), 1'b1);
        exp_beat(3, mk(1, 3, 0), 1'b1);
        exp_beat(0, mk(1, 0, 1), 1'b1);
        exp_beat(1, mk(1, 1, 1), 1'b1);
        wait_data("fair_start", mk(1, 0, 0));
        for (int k = 1; k < 6; k++) begin
            @(negedge clk_i);
            chk("fair_back_to_back", 64'(out_valid_o), 64'd1);
        end
        drain("fair_drain");

        // Lock: port 2 three-beat packet beats port 0, which waits for the last beat.
        #1;
        push_beat(2, mk(2, 2, 0), 1'b0, 0);
        push_beat(2, mk(2, 2, 1), 1'b0, 0);
        push_beat(2, mk(2, 2, 2), 1'b1, 0);
        push_beat(0, mk(2, 0, 0), 1'b1, 0);
        exp_beat(2, mk(2, 2, 0), 1'b0);
        exp_beat(2, mk(2, 2, 1), 1'b0);
        exp_beat(2, mk(2, 2, 2), 1'b1);
        exp_beat(0, mk(2, 0, 0), 1'b1);
        wait_data("lock_beat1", mk(2, 2, 0));
        chk("lock_busy_b1", 64'(busy_o), 64'd1);
        @(negedge clk_i);
        chk("lock_busy_b2", 64'(busy_o), 64'd1);
        @(negedge clk_i);
        chk("lock_b3_data", 64'(out_data_o), 64'(mk(2, 2, 2)));
        chk("lock_busy_b3", 64'(busy_o), 64'd0);
        drain("lock_drain");

        // Backpressure: stall five cycles with a beat held on the output.
        #1;
        for (int n = 0; n < 3; n++) begin
            push_beat(1, mk(3, 1, n), 1'b1, 0);
            exp_beat(1, mk(3, 1, n), 1'b1);
        end
        wait_data("bp_first", mk(3, 1, 0));
        @(posedge clk_i);
        #1 out_ready_i = 1'b0;
        hold = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            if (k == 0) hold = out_data_o;
            else chk("bp_data_stable", 64'(out_data_o), 64'(hold));
            chk("bp_valid_held", 64'(out_valid_o), 64'd1);
            chk("bp_ready_zero", 64'(in_ready_o), 64'd0);
        end
        chk("bp_held_beat", 64'(hold), 64'(mk(3, 1, 1)));
        @(posedge clk_i);
        #1 out_ready_i = 1'b1;
        drain("bp_drain");

        // Bubble in lock: port 1 pauses two cycles mid-packet, port 3 must wait.
        #1;
        push_beat(1, mk(4, 1, 0), 1'b0, 0);
        push_beat(1, mk(4, 1, 1), 1'b0, 2);
        push_beat(1, mk(4, 1, 2), 1'b1, 0);
        exp_beat(1, mk(4, 1, 0), 1'b0);
        exp_beat(1, mk(4, 1, 1), 1'b0);
        exp_beat(1, mk(4, 1, 2), 1'b1);
        wait_data("bub_beat0", mk(4, 1, 0));
        chk("bub_busy", 64'(busy_o), 64'd1);
        #1;
        push_beat(3, mk(4, 3, 0), 1'b1, 0);
        exp_beat(3, mk(4, 3, 0), 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            chk("bub_gap_valid", 64'(out_valid_o), 64'd0);
            chk("bub_gap_busy",  64'(busy_o),      64'd1);
        end
        @(negedge clk_i);
        chk("bub_resume_valid", 64'(out_valid_o), 64'd1);
        chk("bub_resume_data",  64'(out_data_o),  64'(mk(4, 1, 1)));
        drain("bub_drain");

        // Wrap: pointer left at 0 by port 3's last beat, so port 1 precedes port 3.
        #1;
        push_beat(3, mk(5, 3, 0), 1'b1, 0);
        push_beat(1, mk(5, 1, 0), 1'b1, 0);
        exp_beat(1, mk(5, 1, 0), 1'b1);
        exp_beat(3, mk(5, 3, 0), 1'b1);
        drain("wrap_drain");

        // Reset during a lock: the packet is dropped and scanning restarts at port 0.
        #1;
        push_beat(1, mk(6, 1, 0), 1'b1, 0);
        exp_beat(1, mk(6, 1, 0), 1'b1);
        drain("pre_reset_drain");
        #1;
        push_beat(2, mk(6, 2, 0), 1'b0, 0);
        push_beat(2, mk(6, 2, 1), 1'b0, 0);
        push_beat(2, mk(6, 2, 2), 1'b1, 0);
        exp_beat(2, mk(6, 2, 0), 1'b0);
        wait_data("rst_lock_beat0", mk(6, 2, 0));
        chk("rst_lock_busy", 64'(busy_o), 64'd1);
        #1;
        rst_n_i = 1'b0;
        port_q[2].delete();
        gap_cnt[2] = 0;
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_lock_busy_clear",  64'(busy_o),      64'd0);
        chk("rst_lock_valid_clear", 64'(out_valid_o), 64'd0);
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        @(negedge clk_i);
        #1;
        push_beat(3, mk(7, 3, 0), 1'b1, 0);
        push_beat(0, mk(7, 0, 0), 1'b1, 0);
        exp_beat(0, mk(7, 0, 0), 1'b1);
        exp_beat(3, mk(7, 3, 0), 1'b1);
        drain("post_reset_drain");

        for (int i = 0; i < NP; i++)
            chk("port_queue_empty", 64'(port_q[i].size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required bench completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_hs_arb.md
DATA_HS_ARB -- requirements
Module: data_hs_arb

Interface
REQ-001 The block SHALL have parameter N_PORTS, default 4, giving the number of requester streams (2..16).
REQ-002 The block SHALL have parameter D_WIDTH, default 32, giving the data width per stream.
REQ-003 The block SHALL have port clk_i  input  1  the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n_i  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port in_data_i  input  N_PORTS*D_WIDTH  requester data; port i occupies bits [i*D_WIDTH +: D_WIDTH].
REQ-006 The block SHALL have port in_valid_i  input  N_PORTS  per-requester valid.
REQ-007 The block SHALL have port in_last_i  input  N_PORTS  per-requester end-of-packet marker.
REQ-008 The block SHALL have port in_ready_o  output  N_PORTS  per-requester ready.
REQ-009 The block SHALL have port out_data_o  output  D_WIDTH  registered output data.
REQ-010 The block SHALL have port out_last_o  output  1  registered end-of-packet.
REQ-011 The block SHALL have port out_id_o  output  $clog2(N_PORTS)  registered source port index.
REQ-012 The block SHALL have port out_valid_o  output  1  registered output valid.
REQ-013 The block SHALL have port out_ready_i  input  1  downstream ready.
REQ-014 The block SHALL have port busy_o  output  1  high while a packet is locked (state LOCK).

Function
REQ-015 Stage enable SHALL be stage_en = out_ready_i | ~out_valid_o.
REQ-016 Output SHALL be one register stage: an accepted beat appears on out_* the next cycle, so latency is 1 cycle.
REQ-017 In IDLE, grant SHALL go to the first port with in_valid_i set, scanning rr_ptr, rr_ptr+1, ..., N_PORTS-1, 0, ..., wrapping modulo N_PORTS.
REQ-018 In LOCK, grant SHALL be lock_id regardless of other valids; other ports are never granted.
REQ-019 in_ready_o[i] SHALL be stage_en & (i == grant) & grant_active, and zero for all other ports. grant_active is any valid in IDLE, and constant 1 in LOCK.
REQ-020 A transfer SHALL occur when stage_en & in_valid_i[grant] & in_ready_o[grant].
REQ-021 On a transfer, the block SHALL load out_data_o, out_last_o and out_id_o from the granted port and set out_valid_o to 1.
REQ-022 When stage_en is high with no transfer, out_valid_o SHALL go to 0; out_data_o, out_last_o and out_id_o hold.
REQ-023 When stage_en is low, all out_* SHALL hold, all in_ready_o are 0, and state and rr_ptr hold.
REQ-024 IDLE -> LOCK SHALL occur on a transfer with in_last_i=0, capturing lock_id = grant.
REQ-025 LOCK -> IDLE SHALL occur on a transfer from lock_id with in_last_i=1.
REQ-026 A single-beat packet (last=1 in IDLE) SHALL stay in IDLE.
REQ-027 rr_ptr SHALL update to (grant+1) mod N_PORTS only on a transfer with in_last_i=1; grant N_PORTS-1 wraps rr_ptr to 0.
REQ-028 In LOCK with in_valid_i[lock_id]=0, the block SHALL insert bubbles (out_valid_o drops per REQ-022) and stay locked indefinitely.
REQ-029 Requester data, valid and last SHALL NOT be registered or altered before the output stage.

Reset
REQ-030 When rst_n_i=0 at a clock edge, the block SHALL clear out_valid_o, out_last_o, out_data_o and out_id_o to 0, set state to IDLE, set rr_ptr and lock_id to 0, and set busy_o to 0.
REQ-031 Reset asserted mid-packet SHALL abandon the lock; the next grant follows REQ-017 from rr_ptr=0.
REQ-032 in_ready_o SHALL follow REQ-019 from the reset register values, so it is non-zero during reset if out_ready_i or valids permit; no transfer takes effect while rst_n_i=0.

Structure
REQ-033 Package data_hs_pkg SHALL hold the state enum arb_state_t {IDLE, LOCK} and the function computing the index width.
REQ-034 Sub-module rr_pick SHALL implement the combinational round-robin picker: inputs req vector and ptr; outputs grant index and any.

Verification
REQ-035 Reset: hold rst_n_i=0 for 2 cycles with random inputs -> out_valid_o=0, out_id_o=0, busy_o=0 on release.
REQ-036 Fairness: ports 0-3 all valid with single-beat packets and out_ready_i=1 -> out_id_o sequence 0,1,2,3,0,1 with one beat per cycle.
REQ-037 Lock: port 2 sends a 3-beat packet (last on beat 3) while port 0 is valid -> out_id_o=2,2,2 then 0; busy_o is high from the cycle after beat 1 until the cycle after beat 3.
REQ-038 Backpressure: out_ready_i=0 for 5 cycles while out_valid_o=1 -> out_data_o stable and in_ready_o=0 on all ports; zero beats lost or duplicated.
REQ-039 Bubble in lock: port 1 mid-packet drops valid for 2 cycles while port 3 is valid -> 2 cycles with out_valid_o=0; port 3 is not granted until after port 1's last beat.
REQ-040 Wrap and reset mid-packet: rr_ptr=3 with port 3 packet ending -> next grant scans from 0; reset during a lock -> busy_o=0 and a fresh grant starts from port 0.
